// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch unit: bus widths, reset PC and FSM encoding.
package ifu_pkg;

  localparam int                IFU_PC_W     = 32;
  localparam int                IFU_INST_W   = 32;
  localparam logic [31:0]       IFU_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ifu_pc_gen.sv
// Program counter: redirect priority (branch over bypass), word alignment and sequential increment.
module ifu_pc_gen
  import ifu_pkg::*;
#(
  parameter int              PC_W     = IFU_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            br_en_i,
  input  logic [PC_W-1:0] br_npc_i,
  input  logic            byp_en_i,
  input  logic [PC_W-1:0] byp_npc_i,
  input  logic            inc_i,
  output logic            redir_o,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d, target;

  assign redir_o = br_en_i | byp_en_i;
  assign pc_o    = pc_q;

  // The branch comes from an older instruction than the decode bypass, so it wins.
  always_comb begin
    target      = br_en_i ? br_npc_i : byp_npc_i;
    target[1:0] = 2'b00;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d = pc_q;
    if (redir_o)    pc_d = target;
    else if (inc_i) pc_d = pc_q + PC_W'(4);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/ifu.sv
// Instruction-fetch stage: one outstanding imem request, squash-on-redirect, registered {pc, inst}
// presented to decode with a valid/ready handshake.
module ifu
  import ifu_pkg::*;
#(
  parameter int              PC_W     = IFU_PC_W,
  parameter int              INST_W   = IFU_INST_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              br_en_i,
  input  logic [PC_W-1:0]   br_npc_i,
  input  logic              byp_en_i,
  input  logic [PC_W-1:0]   byp_npc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [PC_W-1:0]   imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  output logic              f_valid_o,
  input  logic              D_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o
);

  ifu_state_e        state_q, state_d;
  logic              kill_q, kill_d;
  logic [PC_W-1:0]   hold_q, hold_d;
  logic [PC_W-1:0]   pc_out_q, pc_out_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   pc;
  logic              redir;
  logic              inc;

  ifu_pc_gen #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clock     (clock),
    .reset     (reset),
    .br_en_i   (br_en_i),
    .br_npc_i  (br_npc_i),
    .byp_en_i  (byp_en_i),
    .byp_npc_i (byp_npc_i),
    .inc_i     (inc),
    .redir_o   (redir),
    .pc_o      (pc)
  );

  always_comb begin
    state_d          = state_q;
    kill_d           = kill_q;
    hold_d           = hold_q;
    pc_out_d         = pc_out_q;
    inst_d           = inst_q;
    inc              = 1'b0;
    imem_req_valid_o = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_valid_o = 1'b1;
        if (imem_req_ready_i) begin
          state_d = WAIT;
          if (redir) kill_d = 1'b1;
        end else if (redir && !kill_q) begin
          // Request must stay stable while valid, so remember the address already on the bus.
          kill_d = 1'b1;
          hold_d = pc;
        end
      end
      WAIT: begin
        if (imem_rsp_valid_i) begin
          if (kill_q || redir) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d   = imem_rsp_data_i;
            pc_out_d = pc;
            state_d  = OUT;
          end
        end else if (redir) begin
          kill_d = 1'b1;
        end
      end
      OUT: begin
        if (redir) begin
          state_d = REQ;
        end else if (D_ready_i) begin
          inc     = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // kill_q in REQ only arises from an unaccepted redirect, so it selects the held address.
  assign imem_req_addr_o = (state_q == REQ && kill_q) ? hold_q : pc;
  assign f_valid_o       = (state_q == OUT) && !redir;
  assign pc_o            = pc_out_q;
  assign inst_o          = inst_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      kill_q   <= 1'b0;
      hold_q   <= '0;
      pc_out_q <= '0;
      inst_q   <= '0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      hold_q   <= hold_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed, table-driven bench for ifu: per-cycle inputs with hand-computed expected outputs.
module tb_ifu;

  logic        clock = 1'b0;
  logic        reset;
  logic        br_en_i, byp_en_i;
  logic [31:0] br_npc_i, byp_npc_i;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        f_valid_o, D_ready_i;
  logic [31:0] pc_o, inst_o;

  int n_tests = 0;
  int n_fail  = 0;

  ifu dut (
    .clock            (clock),
    .reset            (reset),
    .br_en_i          (br_en_i),
    .br_npc_i         (br_npc_i),
    .byp_en_i         (byp_en_i),
    .byp_npc_i        (byp_npc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .f_valid_o        (f_valid_o),
    .D_ready_i        (D_ready_i),
    .pc_o             (pc_o),
    .inst_o           (inst_o)
  );

  always #5 clock = ~clock;

  // One cycle: inputs driven during the cycle, outputs expected in the same cycle.
  typedef struct {
    logic        rdy;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        br;
    logic [31:0] br_npc;
    logic        byp;
    logic [31:0] byp_npc;
    logic        d_rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  localparam int NV = 39;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives, checks mid-cycle, then advances to the next posedge+1.
  task automatic step(input vec_t v, input logic rst, input string tag);
    reset            = rst;
    imem_req_ready_i = v.rdy;
    imem_rsp_valid_i = v.rsp_v;
    imem_rsp_data_i  = v.rsp_d;
    br_en_i          = v.br;
    br_npc_i         = v.br_npc;
    byp_en_i         = v.byp;
    byp_npc_i        = v.byp_npc;
    D_ready_i        = v.d_rdy;
    #3;
    check({tag, ".req_valid"}, 32'(imem_req_valid_o), 32'(v.e_req));
    if (v.e_req) check({tag, ".req_addr"}, imem_req_addr_o, v.e_addr);
    check({tag, ".f_valid"}, 32'(f_valid_o), 32'(v.e_fv));
    if (v.e_fv) begin
      check({tag, ".pc"}, pc_o, v.e_pc);
      check({tag, ".inst"}, inst_o, v.e_inst);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_regs(input string tag);
    check({tag, ".pc_zero"}, pc_o, 32'h0);
    check({tag, ".inst_zero"}, inst_o, 32'h0);
  endtask

  initial begin
    //            rdy rsp  rsp_d          br  br_npc         byp byp_npc        drdy req addr           fv  pc             inst
    // basic fetch: accept in c1, rsp in c2, f_valid in c3
    vecs[0]  = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[1]  = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 1, 32'h8000_0000,  0, 32'h0,          32'h0};
    vecs[2]  = '{1, 1, 32'hAAAA_0001,  0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[3]  = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          1, 32'h8000_0000,  32'hAAAA_0001};
    vecs[4]  = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 1, 32'h8000_0004,  0, 32'h0,          32'h0};
    vecs[5]  = '{1, 1, 32'hAAAA_0002,  0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          32'h0};
    // decode stalls for 5 cycles, handshake in the 6th
    vecs[6]  = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1, 32'h8000_0004,  32'hAAAA_0002};
    vecs[7]  = '{1, 1, 32'hDEAD_0009,  0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1, 32'h8000_0004,  32'hAAAA_0002};
    vecs[8]  = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1, 32'h8000_0004,  32'hAAAA_0002};
    vecs[9]  = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1, 32'h8000_0004,  32'hAAAA_0002};
    vecs[10] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          1, 32'h8000_0004,  32'hAAAA_0002};
    vecs[11] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          1, 32'h8000_0004,  32'hAAAA_0002};
    vecs[12] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 1, 32'h8000_0008,  0, 32'h0,          32'h0};
    // bypass in WAIT before the response; late response is dropped
    vecs[13] = '{1, 0, 32'h0,          0, 32'h0,          1, 32'h8000_0100,  1, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[14] = '{1, 1, 32'hDEAD_0001,  0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[15] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 1, 32'h8000_0100,  0, 32'h0,          32'h0};
    // branch and bypass together in WAIT with a same-cycle response: branch wins, rsp dropped
    vecs[16] = '{1, 1, 32'hDEAD_0005,  1, 32'h8000_0200,  1, 32'h8000_0300,  1, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[17] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 1, 32'h8000_0200,  0, 32'h0,          32'h0};
    vecs[18] = '{1, 1, 32'hAAAA_0004,  0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[19] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          1, 32'h8000_0200,  32'hAAAA_0004};
    // redirect in REQ while not accepted: address held, then response squashed
    vecs[20] = '{0, 0, 32'h0,          1, 32'h8000_0400,  0, 32'h0,          1, 1, 32'h8000_0204,  0, 32'h0,          32'h0};
    vecs[21] = '{0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 1, 32'h8000_0204,  0, 32'h0,          32'h0};
    vecs[22] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 1, 32'h8000_0204,  0, 32'h0,          32'h0};
    vecs[23] = '{1, 1, 32'hDEAD_0002,  0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[24] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 1, 32'h8000_0400,  0, 32'h0,          32'h0};
    vecs[25] = '{1, 1, 32'hAAAA_0005,  0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          32'h0};
    // redirect in OUT with decode ready: no handshake; misaligned target is word-aligned
    vecs[26] = '{1, 0, 32'h0,          0, 32'h0,          1, 32'h8000_0106,  1, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[27] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 1, 32'h8000_0104,  0, 32'h0,          32'h0};
    vecs[28] = '{1, 1, 32'hAAAA_0006,  0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[29] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          1, 32'h8000_0104,  32'hAAAA_0006};
    // redirect in the same cycle a request is accepted; then pc wrap from 0xFFFF_FFFC
    vecs[30] = '{1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0,          1, 1, 32'h8000_0108,  0, 32'h0,          32'h0};
    vecs[31] = '{1, 1, 32'hDEAD_0003,  0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[32] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 1, 32'hFFFF_FFFC,  0, 32'h0,          32'h0};
    vecs[33] = '{1, 1, 32'hAAAA_0007,  0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[34] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC,  32'hAAAA_0007};
    vecs[35] = '{1, 1, 32'hDEAD_0004,  0, 32'h0,          0, 32'h0,          1, 1, 32'h0000_0000,  0, 32'h0,          32'h0};
    vecs[36] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[37] = '{1, 1, 32'hAAAA_0008,  0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          32'h0};
    vecs[38] = '{1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0000,  32'hAAAA_0008};

    // Reset state.
    reset            = 1'b1;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    br_en_i          = 1'b0;
    br_npc_i         = '0;
    byp_en_i         = 1'b0;
    byp_npc_i        = '0;
    D_ready_i        = 1'b0;
    @(posedge clock);
    #4;
    check("rst.req_valid", 32'(imem_req_valid_o), 32'h0);
    check("rst.f_valid", 32'(f_valid_o), 32'h0);
    check_reset_regs("rst");
    @(posedge clock);
    #1;

    for (int i = 0; i < NV; i++) step(vecs[i], 1'b0, $sformatf("v%0d", i));

    // Reset asserted mid-fetch, then a stale response after release is ignored.
    step('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h0000_0004, 0, 32'h0, 32'h0}, 1'b0, "mr.req");
    step('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0,         0, 32'h0, 32'h0}, 1'b1, "mr.wait_rst");
    check_reset_regs("mr.after_rst");
    step('{1, 1, 32'hDEAD_00FF, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 32'h0}, 1'b0, "mr.idle_stale");
    step('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h8000_0000, 0, 32'h0, 32'h0}, 1'b0, "mr.req2");
    step('{1, 1, 32'hCCCC_0001, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 32'h0}, 1'b0, "mr.rsp");
    step('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h8000_0000, 32'hCCCC_0001}, 1'b0, "mr.out");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
